// File: rtl/motion_pkg.sv
// motion_pkg: shared definitions for the motion step executor.
// Holds the movement command codes, the executor state enum and the
// coil pattern tables. MOTION_HALFSTEP_EN selects the 8-entry half-step
// table and widens the phase index to 3 bits; otherwise the 4-entry
// full-step table is used with a 2-bit index.
package motion_pkg;

    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_RIGHT = 4'b0010;
    localparam logic [3:0] MV_BACK  = 4'b0100;
    localparam logic [3:0] MV_LEFT  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Element [0] is the rightmost entry of each concatenation.
    localparam logic [3:0][3:0] FULL_STEP_TABLE = {
        4'b1100, 4'b0110, 4'b0011, 4'b1001
    };

    localparam logic [7:0][3:0] HALF_STEP_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

`ifdef MOTION_HALFSTEP_EN
    localparam int PHASE_W = 3;
`else
    localparam int PHASE_W = 2;
`endif

    // Coil pattern for a phase index; the index width matches the table
    // length so the index wraps naturally.
    function automatic logic [3:0] phase_pattern(input logic [PHASE_W-1:0] idx);
`ifdef MOTION_HALFSTEP_EN
        return HALF_STEP_TABLE[idx];
`else
        return FULL_STEP_TABLE[idx];
`endif
    endfunction

    // True for the four codes that produce wheel motion.
    function automatic logic is_motion_code(input logic [3:0] code);
        logic result;
        result = 1'b0;
        case (code)
            MV_FWD, MV_RIGHT, MV_BACK, MV_LEFT: result = 1'b1;
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/motion_step_executor_phase_gen.sv
// stepper_phase_gen: phase index and coil driver for one wheel.
// The index advances or retreats by one on each step strobe and is kept
// while disabled, so a wheel resumes where it stopped. The coil output is
// registered from the next index so it changes on the same edge as the index.
// Table size follows MOTION_HALFSTEP_EN through motion_pkg.
module stepper_phase_gen
    import motion_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       enable,
    output logic [3:0] coil
);

    localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);

    logic [PHASE_W-1:0] phase_idx;
    logic [PHASE_W-1:0] phase_idx_next;

    // Next phase index: one step forward or back when strobed.
    always_comb begin
        phase_idx_next = phase_idx;
        if (step) begin
            phase_idx_next = dir ? (phase_idx + PHASE_ONE) : (phase_idx - PHASE_ONE);
        end
    end

    // Index register and registered coil pattern, blanked when disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_idx <= '0;
            coil      <= 4'b0000;
        end else begin
            phase_idx <= phase_idx_next;
            coil      <= enable ? phase_pattern(phase_idx_next) : 4'b0000;
        end
    end

endmodule

// File: rtl/motion_step_executor.sv
// motion_step_executor: accepts one movement command per valid/ready
// handshake and runs it as a fixed-length two-wheel stepper move,
// followed by a settle hold, then pulses done. Stop codes complete at
// once with done, unknown codes are rejected with cmd_err, and halt aborts
// a move without done while keeping both wheels' phase indices.
// Optional build macro: MOTION_HALFSTEP_EN (half-step coil table).
module motion_step_executor
    import motion_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int STEPS_PER_MOVE = 200,
    parameter int SETTLE_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] movement_sel,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       halt,
    output logic [3:0] coil_l,
    output logic [3:0] coil_r,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int STEP_W   = $clog2(STEPS_PER_MOVE + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE     = DIV_W'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEPS_PER_MOVE - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE    = STEP_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);

    state_t              state;
    state_t              state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                dir_l;
    logic                dir_r;
    logic                step_strobe;
    logic                accept;
    logic                phase_en;

    assign cmd_ready = (state == ST_IDLE) & ~halt;
    assign accept    = cmd_valid & cmd_ready;
    assign phase_en  = (state_next != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and step strobe; halt wins over a coincident step.
    always_comb begin
        state_next  = state;
        step_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_motion_code(movement_sel)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_IDLE;
                end else if (div_cnt == DIV_LAST) begin
                    step_strobe = 1'b1;
                    if (step_cnt == STEP_LAST) begin
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (halt || (settle_cnt == SETTLE_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters, latched wheel directions and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            dir_l      <= 1'b0;
            dir_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            busy    <= (state_next != ST_IDLE);
            done    <= (accept && (movement_sel == MV_STOP))
                     || ((state == ST_SETTLE) && !halt && (settle_cnt == SETTLE_LAST));
            cmd_err <= accept && (movement_sel != MV_STOP) && !is_motion_code(movement_sel);

            if (accept) begin
                dir_l <= (movement_sel == MV_FWD) || (movement_sel == MV_RIGHT);
                dir_r <= (movement_sel == MV_FWD) || (movement_sel == MV_LEFT);
            end

            div_cnt <= ((state == ST_RUN) && (state_next == ST_RUN) && !step_strobe)
                     ? (div_cnt + DIV_ONE) : '0;

            if ((state == ST_RUN) && (state_next == ST_RUN)) begin
                if (step_strobe) begin
                    step_cnt <= step_cnt + STEP_ONE;
                end
            end else begin
                step_cnt <= '0;
            end

            settle_cnt <= ((state == ST_SETTLE) && (state_next == ST_SETTLE))
                        ? (settle_cnt + SETTLE_ONE) : '0;
        end
    end

    stepper_phase_gen u_phase_l (
        .clk    (clk),
        .rst    (rst),
        .step   (step_strobe),
        .dir    (dir_l),
        .enable (phase_en),
        .coil   (coil_l)
    );

    stepper_phase_gen u_phase_r (
        .clk    (clk),
        .rst    (rst),
        .step   (step_strobe),
        .dir    (dir_r),
        .enable (phase_en),
        .coil   (coil_r)
    );

endmodule

// File: tb/tb_motion_step_executor.sv
// tb_motion_step_executor: scoreboard bench for motion_step_executor.
// A command-level model predicts each command's response kind, busy
// length and per-cycle coil sequence; a monitor captures the DUT's
// behaviour and compares whenever done, cmd_err or a busy drop appears.
module tb_motion_step_executor;

    localparam int CLK_DIV = 4;
    localparam int STEPS   = 3;
    localparam int SETTLE  = 2;
    localparam int TOTAL   = STEPS * CLK_DIV + SETTLE;

`ifdef MOTION_HALFSTEP_EN
    localparam int TBL_LEN = 8;
`else
    localparam int TBL_LEN = 4;
`endif

    localparam int KIND_DONE = 1;
    localparam int KIND_ERR  = 2;
    localparam int KIND_HALT = 3;

    typedef struct {
        int               kind;
        int               len;
        logic [0:15][3:0] l;
        logic [0:15][3:0] r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] movement_sel;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       halt;
    logic [3:0] coil_l;
    logic [3:0] coil_r;
    logic       busy;
    logic       done;
    logic       cmd_err;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    int   mi_l = 0;
    int   mi_r = 0;

    motion_step_executor #(
        .CLK_DIV        (CLK_DIV),
        .STEPS_PER_MOVE (STEPS),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .movement_sel (movement_sel),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .halt         (halt),
        .coil_l       (coil_l),
        .coil_r       (coil_r),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] pattern(input int idx);
        logic [3:0] p;
        p = 4'b0000;
`ifdef MOTION_HALFSTEP_EN
        case (idx)
            0: p = 4'b0001; 1: p = 4'b0011; 2: p = 4'b0010; 3: p = 4'b0110;
            4: p = 4'b0100; 5: p = 4'b1100; 6: p = 4'b1000; 7: p = 4'b1001;
            default: p = 4'b0000;
        endcase
`else
        case (idx)
            0: p = 4'b1001; 1: p = 4'b0011; 2: p = 4'b0110; 3: p = 4'b1100;
            default: p = 4'b0000;
        endcase
`endif
        return p;
    endfunction

    function automatic int wrapIdx(input int x);
        return ((x % TBL_LEN) + TBL_LEN) % TBL_LEN;
    endfunction

    // Command-level model: which index each busy cycle shows, and where
    // each wheel ends up. halt_at > 0 means halt is sampled in that cycle.
    function automatic exp_t modelCommand(input logic [3:0] code, input int halt_at);
        exp_t e;
        int   dl;
        int   dr;
        int   shown;
        int   steps_done;
        e.kind = 0;
        e.len  = 0;
        e.l    = '0;
        e.r    = '0;
        dl     = 0;
        dr     = 0;
        case (code)
            4'b0001: begin dl =  1; dr =  1; end
            4'b0100: begin dl = -1; dr = -1; end
            4'b0010: begin dl =  1; dr = -1; end
            4'b1000: begin dl = -1; dr =  1; end
            4'b0000: begin e.kind = KIND_DONE; return e; end
            default: begin e.kind = KIND_ERR;  return e; end
        endcase
        e.kind = (halt_at > 0) ? KIND_HALT : KIND_DONE;
        e.len  = (halt_at > 0) ? halt_at : TOTAL;
        for (int c = 1; c <= e.len; c++) begin
            shown = (c - 1) / CLK_DIV;
            if (shown > STEPS) shown = STEPS;
            e.l[c-1] = pattern(wrapIdx(mi_l + dl * shown));
            e.r[c-1] = pattern(wrapIdx(mi_r + dr * shown));
        end
        steps_done = (halt_at > 0) ? (halt_at - 1) / CLK_DIV : STEPS;
        if (steps_done > STEPS) steps_done = STEPS;
        mi_l = wrapIdx(mi_l + dl * steps_done);
        mi_r = wrapIdx(mi_r + dr * steps_done);
        return e;
    endfunction

    // Offer a command until accepted, record its expected response, and
    // optionally raise halt during busy cycle halt_at.
    task automatic applyStimulus(input logic [3:0] code, input int halt_at);
        logic sampled;
        bit   accepted;
        accepted = 1'b0;
        @(negedge clk);
        movement_sel = code;
        cmd_valid    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sampled = cmd_ready;
            @(posedge clk);
            if (sampled) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(modelCommand(code, halt_at));
        end
        #1 cmd_valid = 1'b0;
        if (accepted && halt_at > 0) begin
            repeat (halt_at - 1) @(posedge clk);
            #1 halt = 1'b1;
            @(posedge clk);
            #1 halt = 1'b0;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: capture busy-cycle coils, compare on each response.
    logic [0:15][3:0] cap_l;
    logic [0:15][3:0] cap_r;
    int               mon_n     = 0;
    int               ready_bad = 0;
    logic             prev_busy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (!rst) begin
            cap_l     = '0;
            cap_r     = '0;
            mon_n     = 0;
            ready_bad = 0;
            prev_busy = 1'b0;
        end else begin
            if (done || cmd_err || (prev_busy && !busy)) begin
                kind = done ? KIND_DONE : (cmd_err ? KIND_ERR : KIND_HALT);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 64'(kind), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_kind", 64'(kind), 64'(e.kind));
                    checkOutput("busy_len", 64'(mon_n), 64'(e.len));
                    checkOutput("coil_l_seq", cap_l, e.l);
                    checkOutput("coil_r_seq", cap_r, e.r);
                    checkOutput("ready_while_busy", 64'(ready_bad), 64'd0);
                    checkOutput("idle_coils", {coil_l, coil_r}, 64'd0);
                end
                cap_l     = '0;
                cap_r     = '0;
                mon_n     = 0;
                ready_bad = 0;
            end
            if (busy) begin
                if (mon_n < 16) begin
                    cap_l[mon_n] = coil_l;
                    cap_r[mon_n] = coil_r;
                end
                mon_n++;
                if (cmd_ready) ready_bad++;
            end
            prev_busy = busy;
        end
    end

    // Main sequence: directed scenarios, then randomized commands.
    initial begin
        int         pick;
        int         k;
        logic [3:0] code;

        rst          = 1'b0;
        halt         = 1'b0;
        cmd_valid    = 1'b0;
        movement_sel = 4'b0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_coil_l", 64'(coil_l), 64'd0);
        checkOutput("rst_coil_r", 64'(coil_r), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_cmd_err", 64'(cmd_err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 64'(cmd_ready), 64'd1);

        applyStimulus(4'b0001, 0);
        applyStimulus(4'b0010, 0);
        applyStimulus(4'b0000, 0);
        applyStimulus(4'b0101, 0);
        waitIdle();

        // halt while idle must block acceptance
        @(negedge clk);
        halt         = 1'b1;
        cmd_valid    = 1'b1;
        movement_sel = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            checkOutput("ready_under_halt", 64'(cmd_ready), 64'd0);
            checkOutput("busy_under_halt", 64'(busy), 64'd0);
        end
        cmd_valid = 1'b0;
        halt      = 1'b0;

        // reset in the middle of a move
        applyStimulus(4'b0001, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midrst_coil_l", 64'(coil_l), 64'd0);
        checkOutput("midrst_coil_r", 64'(coil_r), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        exp_q.delete();
        mi_l = 0;
        mi_r = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // halt in cycle 6, then resume
        applyStimulus(4'b0001, 6);
        applyStimulus(4'b0001, 0);
        applyStimulus(4'b0100, 0);
        applyStimulus(4'b1000, 0);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: code = 4'b0001;
                1: code = 4'b0010;
                2: code = 4'b0100;
                3: code = 4'b1000;
                4: code = 4'b0000;
                default: code = 4'($urandom_range(0, 15));
            endcase
            k = 0;
            if ((code == 4'b0001 || code == 4'b0010 || code == 4'b0100 || code == 4'b1000)
                && ($urandom_range(0, 3) == 0)) begin
                k = $urandom_range(1, TOTAL);
                if ((k % CLK_DIV == 0) && (k <= STEPS * CLK_DIV)) k = k - 1;
            end
            applyStimulus(code, k);
        end
        waitIdle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
